// File: rtl/axi_master_arb_pkg.sv
// Shared types and AXI constants for the multi-port AXI4 master bridge.
package axi_master_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] CACHE_DEFAULT = 4'b0010;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;

  // Index width that stays legal for a single-port configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_master_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
module axi_master_arb_rr_arbiter
  import axi_master_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) grant[idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = idx;
  end

  // Pointer starts on the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_master_arb.sv
// AXI4 master bridge: round-robin over NUM_PORTS rw ports, one transaction in flight,
// INCR read bursts up to 256 beats, single-beat writes.
module axi_master_arb
  import axi_master_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              rw_req_i,
  input  logic [NUM_PORTS-1:0]              rw_wen_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   rw_addr_i,
  input  logic [NUM_PORTS*3-1:0]            rw_size_i,
  input  logic [NUM_PORTS*8-1:0]            rw_len_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   rw_wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] rw_wmask_i,
  output logic [NUM_PORTS-1:0]              rw_rvalid_o,
  output logic [DATA_WIDTH-1:0]             rw_rdata_o,
  output logic                              rw_rlast_o,
  output logic [NUM_PORTS-1:0]              rw_done_o,
  output logic [1:0]                        rw_resp_o,
  output logic                              axi_aw_valid_o,
  input  logic                              axi_aw_ready_i,
  output logic [ID_WIDTH-1:0]               axi_aw_id_o,
  output logic [ADDR_WIDTH-1:0]             axi_aw_addr_o,
  output logic [7:0]                        axi_aw_len_o,
  output logic [2:0]                        axi_aw_size_o,
  output logic [1:0]                        axi_aw_burst_o,
  output logic                              axi_aw_lock_o,
  output logic [3:0]                        axi_aw_cache_o,
  output logic [2:0]                        axi_aw_prot_o,
  output logic [3:0]                        axi_aw_qos_o,
  output logic [3:0]                        axi_aw_region_o,
  output logic [USER_WIDTH-1:0]             axi_aw_user_o,
  output logic                              axi_w_valid_o,
  input  logic                              axi_w_ready_i,
  output logic [DATA_WIDTH-1:0]             axi_w_data_o,
  output logic [DATA_WIDTH/8-1:0]           axi_w_strb_o,
  output logic                              axi_w_last_o,
  output logic [USER_WIDTH-1:0]             axi_w_user_o,
  output logic                              axi_b_ready_o,
  input  logic                              axi_b_valid_i,
  input  logic [1:0]                        axi_b_resp_i,
  input  logic [ID_WIDTH-1:0]               axi_b_id_i,
  output logic                              axi_ar_valid_o,
  input  logic                              axi_ar_ready_i,
  output logic [ID_WIDTH-1:0]               axi_ar_id_o,
  output logic [ADDR_WIDTH-1:0]             axi_ar_addr_o,
  output logic [7:0]                        axi_ar_len_o,
  output logic [2:0]                        axi_ar_size_o,
  output logic [1:0]                        axi_ar_burst_o,
  output logic                              axi_ar_lock_o,
  output logic [3:0]                        axi_ar_cache_o,
  output logic [2:0]                        axi_ar_prot_o,
  output logic [3:0]                        axi_ar_qos_o,
  output logic [3:0]                        axi_ar_region_o,
  output logic [USER_WIDTH-1:0]             axi_ar_user_o,
  output logic                              axi_r_ready_o,
  input  logic                              axi_r_valid_i,
  input  logic [DATA_WIDTH-1:0]             axi_r_data_i,
  input  logic [1:0]                        axi_r_resp_i,
  input  logic                              axi_r_last_i,
  input  logic [ID_WIDTH-1:0]               axi_r_id_i
);

  localparam int IW     = idx_width(NUM_PORTS);
  localparam int STRB_W = DATA_WIDTH / 8;

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   arb_grant;
  logic [IW-1:0]          arb_idx;
  logic                   grant_en;
  logic                   ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_w_done;

  logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [2:0]             size_q, size_d;
  logic [7:0]             len_q, len_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]      wmask_q, wmask_d;
  logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0]             err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d, done_q, done_d;
  logic                   rlast_q, rlast_d;
  logic [1:0]             resp_q, resp_d;

  logic unused_ids;
  assign unused_ids = ^{axi_b_id_i, axi_r_id_i};

  // The requester still holds req during its done pulse, so no grant that cycle.
  assign grant_en = (state_q == S_IDLE) && (|rw_req_i) && !(|done_q);

  axi_master_arb_rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rw_req_i),
    .advance (grant_en),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  assign ar_hs     = axi_ar_valid_o && axi_ar_ready_i;
  assign r_hs      = axi_r_ready_o  && axi_r_valid_i;
  assign aw_hs     = axi_aw_valid_o && axi_aw_ready_i;
  assign w_hs      = axi_w_valid_o  && axi_w_ready_i;
  assign b_hs      = axi_b_ready_o  && axi_b_valid_i;
  assign aw_w_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (grant_en) state_d = rw_wen_i[arb_idx] ? S_AW_W : S_AR;
      S_AR:   if (ar_hs) state_d = S_R;
      S_R:    if (r_hs && axi_r_last_i) state_d = S_IDLE;
      S_AW_W: if (aw_w_done) state_d = S_B;
      S_B:    if (b_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    axi_ar_valid_o = (state_q == S_AR);
    axi_r_ready_o  = (state_q == S_R);
    axi_aw_valid_o = (state_q == S_AW_W) && !aw_done_q;
    axi_w_valid_o  = (state_q == S_AW_W) && !w_done_q;
    axi_b_ready_o  = (state_q == S_B);
  end

  always_comb begin
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    addr_d    = addr_q;
    size_d    = size_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    rvalid_d  = '0;
    done_d    = '0;
    rlast_d   = 1'b0;
    if (grant_en) begin
      gnt_d     = arb_grant;
      gidx_d    = arb_idx;
      addr_d    = rw_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
      size_d    = rw_size_i[arb_idx*3 +: 3];
      len_d     = rw_wen_i[arb_idx] ? 8'd0 : rw_len_i[arb_idx*8 +: 8];
      wdata_d   = rw_wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      wmask_d   = rw_wmask_i[arb_idx*STRB_W +: STRB_W];
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      err_d     = RESP_OKAY;
    end
    if (aw_hs) aw_done_d = 1'b1;
    if (w_hs)  w_done_d  = 1'b1;
    // The last non-OKAY beat wins; the final beat's own resp is folded in directly.
    if (r_hs) begin
      rdata_d  = axi_r_data_i;
      rvalid_d = gnt_q;
      if (axi_r_resp_i != RESP_OKAY) err_d = axi_r_resp_i;
      if (axi_r_last_i) begin
        rlast_d = 1'b1;
        done_d  = gnt_q;
        resp_d  = (axi_r_resp_i != RESP_OKAY) ? axi_r_resp_i : err_q;
      end
    end
    if (b_hs) begin
      done_d = gnt_q;
      resp_d = axi_b_resp_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      gidx_q    <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= RESP_OKAY;
      rdata_q   <= '0;
      rvalid_q  <= '0;
      done_q    <= '0;
      rlast_q   <= 1'b0;
      resp_q    <= RESP_OKAY;
    end else begin
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      done_q    <= done_d;
      rlast_q   <= rlast_d;
      resp_q    <= resp_d;
    end
  end

  assign rw_rvalid_o = rvalid_q;
  assign rw_rdata_o  = rdata_q;
  assign rw_rlast_o  = rlast_q;
  assign rw_done_o   = done_q;
  assign rw_resp_o   = resp_q;

  assign axi_ar_id_o     = ID_WIDTH'(gidx_q);
  assign axi_ar_addr_o   = addr_q;
  assign axi_ar_len_o    = len_q;
  assign axi_ar_size_o   = size_q;
  assign axi_ar_burst_o  = BURST_INCR;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_cache_o  = CACHE_DEFAULT;
  assign axi_ar_prot_o   = PROT_DEFAULT;
  assign axi_ar_qos_o    = 4'd0;
  assign axi_ar_region_o = 4'd0;
  assign axi_ar_user_o   = '0;

  assign axi_aw_id_o     = ID_WIDTH'(gidx_q);
  assign axi_aw_addr_o   = addr_q;
  assign axi_aw_len_o    = 8'd0;
  assign axi_aw_size_o   = size_q;
  assign axi_aw_burst_o  = BURST_INCR;
  assign axi_aw_lock_o   = 1'b0;
  assign axi_aw_cache_o  = CACHE_DEFAULT;
  assign axi_aw_prot_o   = PROT_DEFAULT;
  assign axi_aw_qos_o    = 4'd0;
  assign axi_aw_region_o = 4'd0;
  assign axi_aw_user_o   = '0;

  assign axi_w_data_o = wdata_q;
  assign axi_w_strb_o = wmask_q;
  assign axi_w_last_o = 1'b1;
  assign axi_w_user_o = '0;

endmodule

// File: tb/tb_axi_master_arb.sv
// Directed bench for axi_master_arb: the initial block acts as requesters and AXI slave.
module tb_axi_master_arb;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDW = 4;
  localparam int UW  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      rw_req_i, rw_wen_i;
  logic [N*AW-1:0]   rw_addr_i;
  logic [N*3-1:0]    rw_size_i;
  logic [N*8-1:0]    rw_len_i;
  logic [N*DW-1:0]   rw_wdata_i;
  logic [N*DW/8-1:0] rw_wmask_i;
  logic [N-1:0]      rw_rvalid_o, rw_done_o;
  logic [DW-1:0]     rw_rdata_o;
  logic              rw_rlast_o;
  logic [1:0]        rw_resp_o;

  logic              axi_aw_valid_o, axi_aw_ready_i;
  logic [IDW-1:0]    axi_aw_id_o;
  logic [AW-1:0]     axi_aw_addr_o;
  logic [7:0]        axi_aw_len_o;
  logic [2:0]        axi_aw_size_o;
  logic [1:0]        axi_aw_burst_o;
  logic              axi_aw_lock_o;
  logic [3:0]        axi_aw_cache_o;
  logic [2:0]        axi_aw_prot_o;
  logic [3:0]        axi_aw_qos_o, axi_aw_region_o;
  logic [UW-1:0]     axi_aw_user_o;
  logic              axi_w_valid_o, axi_w_ready_i;
  logic [DW-1:0]     axi_w_data_o;
  logic [DW/8-1:0]   axi_w_strb_o;
  logic              axi_w_last_o;
  logic [UW-1:0]     axi_w_user_o;
  logic              axi_b_ready_o, axi_b_valid_i;
  logic [1:0]        axi_b_resp_i;
  logic [IDW-1:0]    axi_b_id_i;
  logic              axi_ar_valid_o, axi_ar_ready_i;
  logic [IDW-1:0]    axi_ar_id_o;
  logic [AW-1:0]     axi_ar_addr_o;
  logic [7:0]        axi_ar_len_o;
  logic [2:0]        axi_ar_size_o;
  logic [1:0]        axi_ar_burst_o;
  logic              axi_ar_lock_o;
  logic [3:0]        axi_ar_cache_o;
  logic [2:0]        axi_ar_prot_o;
  logic [3:0]        axi_ar_qos_o, axi_ar_region_o;
  logic [UW-1:0]     axi_ar_user_o;
  logic              axi_r_ready_o, axi_r_valid_i;
  logic [DW-1:0]     axi_r_data_i;
  logic [1:0]        axi_r_resp_i;
  logic              axi_r_last_i;
  logic [IDW-1:0]    axi_r_id_i;

  axi_master_arb #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rw_req_i(rw_req_i), .rw_wen_i(rw_wen_i), .rw_addr_i(rw_addr_i),
    .rw_size_i(rw_size_i), .rw_len_i(rw_len_i), .rw_wdata_i(rw_wdata_i),
    .rw_wmask_i(rw_wmask_i), .rw_rvalid_o(rw_rvalid_o), .rw_rdata_o(rw_rdata_o),
    .rw_rlast_o(rw_rlast_o), .rw_done_o(rw_done_o), .rw_resp_o(rw_resp_o),
    .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
    .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o),
    .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o),
    .axi_aw_lock_o(axi_aw_lock_o), .axi_aw_cache_o(axi_aw_cache_o),
    .axi_aw_prot_o(axi_aw_prot_o), .axi_aw_qos_o(axi_aw_qos_o),
    .axi_aw_region_o(axi_aw_region_o), .axi_aw_user_o(axi_aw_user_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
    .axi_w_user_o(axi_w_user_o),
    .axi_b_ready_o(axi_b_ready_o), .axi_b_valid_i(axi_b_valid_i),
    .axi_b_resp_i(axi_b_resp_i), .axi_b_id_i(axi_b_id_i),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
    .axi_ar_id_o(axi_ar_id_o), .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o),
    .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o),
    .axi_ar_lock_o(axi_ar_lock_o), .axi_ar_cache_o(axi_ar_cache_o),
    .axi_ar_prot_o(axi_ar_prot_o), .axi_ar_qos_o(axi_ar_qos_o),
    .axi_ar_region_o(axi_ar_region_o), .axi_ar_user_o(axi_ar_user_o),
    .axi_r_ready_o(axi_r_ready_o), .axi_r_valid_i(axi_r_valid_i),
    .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i),
    .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(input int budget);
    int n = 0;
    while (!axi_ar_valid_o && n < budget) begin
      cyc();
      n++;
    end
    chk("ar_valid_wait", 64'(axi_ar_valid_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv;
    logic [1:0] exp_oh;
    rw_req_i = '0; rw_wen_i = '0; rw_addr_i = '0; rw_size_i = '0; rw_len_i = '0;
    rw_wdata_i = '0; rw_wmask_i = '0;
    axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_b_valid_i = 0; axi_b_resp_i = 0; axi_b_id_i = 0;
    axi_ar_ready_i = 0; axi_r_valid_i = 0; axi_r_data_i = 0; axi_r_resp_i = 0;
    axi_r_last_i = 0; axi_r_id_i = 0;

    // Reset state
    repeat (2) cyc();
    chk("rst_ar_valid", 64'(axi_ar_valid_o), 0);
    chk("rst_aw_valid", 64'(axi_aw_valid_o), 0);
    chk("rst_w_valid",  64'(axi_w_valid_o), 0);
    chk("rst_r_ready",  64'(axi_r_ready_o), 0);
    chk("rst_b_ready",  64'(axi_b_ready_o), 0);
    chk("rst_rvalid",   64'(rw_rvalid_o), 0);
    chk("rst_done",     64'(rw_done_o), 0);
    chk("rst_rdata",    rw_rdata_o, 0);
    chk("rst_resp",     64'(rw_resp_o), 0);
    chk("ar_cache",     64'(axi_ar_cache_o), 64'h2);
    chk("aw_cache",     64'(axi_aw_cache_o), 64'h2);
    rst_n = 1'b1;
    cyc();

    // Single read, port 0
    rw_req_i = 2'b01; rw_wen_i = 2'b00;
    rw_addr_i[31:0] = 32'h8000_0000; rw_size_i[2:0] = 3'd3; rw_len_i[7:0] = 8'd0;
    cyc();
    chk("t1_ar_valid", 64'(axi_ar_valid_o), 1);
    chk("t1_ar_id",    64'(axi_ar_id_o), 0);
    chk("t1_ar_addr",  64'(axi_ar_addr_o), 64'h8000_0000);
    chk("t1_ar_len",   64'(axi_ar_len_o), 0);
    chk("t1_ar_size",  64'(axi_ar_size_o), 3);
    chk("t1_ar_burst", 64'(axi_ar_burst_o), 1);
    axi_ar_ready_i = 1;
    cyc();
    axi_ar_ready_i = 0;
    chk("t1_ar_drop",  64'(axi_ar_valid_o), 0);
    chk("t1_r_ready",  64'(axi_r_ready_o), 1);
    axi_r_valid_i = 1; axi_r_data_i = 64'h1122_3344_5566_7788; axi_r_last_i = 1; axi_r_resp_i = 0;
    cyc();
    axi_r_valid_i = 0; axi_r_last_i = 0; rw_req_i = 2'b00;
    chk("t1_rvalid", 64'(rw_rvalid_o), 64'b01);
    chk("t1_rdata",  rw_rdata_o, 64'h1122_3344_5566_7788);
    chk("t1_rlast",  64'(rw_rlast_o), 1);
    chk("t1_done",   64'(rw_done_o), 64'b01);
    chk("t1_resp",   64'(rw_resp_o), 0);
    cyc();
    chk("t1_rvalid_pulse", 64'(rw_rvalid_o), 0);
    chk("t1_done_pulse",   64'(rw_done_o), 0);

    // Port 1 burst of 8 with valid gaps
    rw_req_i = 2'b10; rw_addr_i[63:32] = 32'h0000_1000; rw_len_i[15:8] = 8'd7; rw_size_i[5:3] = 3'd3;
    cyc();
    chk("t2_ar_valid", 64'(axi_ar_valid_o), 1);
    chk("t2_ar_id",    64'(axi_ar_id_o), 1);
    chk("t2_ar_len",   64'(axi_ar_len_o), 7);
    chk("t2_ar_addr",  64'(axi_ar_addr_o), 64'h1000);
    axi_ar_ready_i = 1;
    cyc();
    axi_ar_ready_i = 0;
    sent = 0; rcv = 0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      if (sent < 8 && (c % 3) != 1) begin
        axi_r_valid_i = 1; axi_r_data_i = 64'hB0 + 64'(sent); axi_r_last_i = (sent == 7); sent++;
      end else begin
        axi_r_valid_i = 0; axi_r_last_i = 0;
      end
      cyc();
      if (rw_rvalid_o != 0) begin
        chk("t2_rvalid_port", 64'(rw_rvalid_o), 64'b10);
        chk("t2_rdata", rw_rdata_o, 64'hB0 + 64'(rcv));
        rcv++;
        chk("t2_done", 64'(rw_done_o), (rcv == 8) ? 64'b10 : 64'b00);
      end else begin
        chk("t2_gap_done", 64'(rw_done_o), 0);
      end
    end
    axi_r_valid_i = 0; axi_r_last_i = 0; rw_req_i = 2'b00;
    chk("t2_beats", 64'(rcv), 8);
    cyc();
    chk("t2_done_pulse", 64'(rw_done_o), 0);

    // Write on port 0: w accepted immediately, aw three cycles late, b_resp SLVERR
    rw_req_i = 2'b01; rw_wen_i = 2'b01; rw_addr_i[31:0] = 32'h0000_2000;
    rw_wdata_i[63:0] = 64'hDEAD_BEEF_0123_4567; rw_wmask_i[7:0] = 8'h0F; rw_len_i[7:0] = 8'd5;
    axi_w_ready_i = 1;
    cyc();
    chk("t3_aw_valid", 64'(axi_aw_valid_o), 1);
    chk("t3_w_valid",  64'(axi_w_valid_o), 1);
    chk("t3_aw_id",    64'(axi_aw_id_o), 0);
    chk("t3_aw_addr",  64'(axi_aw_addr_o), 64'h2000);
    chk("t3_aw_len",   64'(axi_aw_len_o), 0);
    chk("t3_w_data",   axi_w_data_o, 64'hDEAD_BEEF_0123_4567);
    chk("t3_w_strb",   64'(axi_w_strb_o), 64'h0F);
    chk("t3_w_last",   64'(axi_w_last_o), 1);
    chk("t3_no_ar",    64'(axi_ar_valid_o), 0);
    cyc();
    chk("t3_w_drop",   64'(axi_w_valid_o), 0);
    chk("t3_aw_hold1", 64'(axi_aw_valid_o), 1);
    cyc();
    chk("t3_aw_hold2", 64'(axi_aw_valid_o), 1);
    chk("t3_no_bready", 64'(axi_b_ready_o), 0);
    axi_aw_ready_i = 1;
    cyc();
    axi_aw_ready_i = 0; axi_w_ready_i = 0;
    chk("t3_aw_drop",  64'(axi_aw_valid_o), 0);
    chk("t3_b_ready",  64'(axi_b_ready_o), 1);
    axi_b_valid_i = 1; axi_b_resp_i = 2'b10;
    cyc();
    axi_b_valid_i = 0; axi_b_resp_i = 0; rw_req_i = 2'b00; rw_wen_i = 2'b00;
    chk("t3_done",   64'(rw_done_o), 64'b01);
    chk("t3_resp",   64'(rw_resp_o), 2);
    chk("t3_rvalid", 64'(rw_rvalid_o), 0);
    cyc();
    chk("t3_done_pulse", 64'(rw_done_o), 0);

    // Port 1 burst of 4 with SLVERR on the third beat
    rw_req_i = 2'b10; rw_addr_i[63:32] = 32'h0000_3000; rw_len_i[15:8] = 8'd3;
    cyc();
    chk("t5_ar_id",  64'(axi_ar_id_o), 1);
    chk("t5_ar_len", 64'(axi_ar_len_o), 3);
    axi_ar_ready_i = 1;
    cyc();
    axi_ar_ready_i = 0;
    for (int b = 0; b < 4; b++) begin
      axi_r_valid_i = 1; axi_r_data_i = 64'hC0 + 64'(b);
      axi_r_resp_i = (b == 2) ? 2'b10 : 2'b00; axi_r_last_i = (b == 3);
      cyc();
      chk("t5_rvalid", 64'(rw_rvalid_o), 64'b10);
      chk("t5_done",   64'(rw_done_o), (b == 3) ? 64'b10 : 64'b00);
    end
    axi_r_valid_i = 0; axi_r_resp_i = 0; axi_r_last_i = 0; rw_req_i = 2'b00;
    chk("t5_resp", 64'(rw_resp_o), 2);
    cyc();
    chk("t5_done_pulse", 64'(rw_done_o), 0);

    // Reset asserted while beat 2 of 4 is on the bus
    rw_req_i = 2'b01; rw_addr_i[31:0] = 32'h0000_4000; rw_len_i[7:0] = 8'd3;
    cyc();
    chk("t6_ar_id", 64'(axi_ar_id_o), 0);
    axi_ar_ready_i = 1;
    cyc();
    axi_ar_ready_i = 0;
    axi_r_valid_i = 1; axi_r_data_i = 64'hD0;
    cyc();
    axi_r_data_i = 64'hD1;
    cyc();
    chk("t6_pre_rvalid", 64'(rw_rvalid_o), 64'b01);
    axi_r_data_i = 64'hD2;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid",  64'(rw_rvalid_o), 0);
    chk("t6_rst_rdata",   rw_rdata_o, 0);
    chk("t6_rst_done",    64'(rw_done_o), 0);
    chk("t6_rst_r_ready", 64'(axi_r_ready_o), 0);
    chk("t6_rst_resp",    64'(rw_resp_o), 0);
    axi_r_valid_i = 0; rw_req_i = 2'b00;
    cyc();
    chk("t6_rst_done2", 64'(rw_done_o), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Both ports requesting continuously: 0,1,0,1,0,1
    rw_req_i = 2'b11; rw_wen_i = 2'b00; rw_len_i = '0;
    rw_addr_i[31:0] = 32'h0000_5000; rw_addr_i[63:32] = 32'h0000_6000;
    for (int k = 0; k < 6; k++) begin
      exp_oh = (k % 2 == 1) ? 2'b10 : 2'b01;
      wait_ar(6);
      chk("t4_ar_id",   64'(axi_ar_id_o), 64'(k % 2));
      chk("t4_ar_addr", 64'(axi_ar_addr_o), (k % 2 == 1) ? 64'h6000 : 64'h5000);
      axi_ar_ready_i = 1;
      cyc();
      axi_ar_ready_i = 0;
      axi_r_valid_i = 1; axi_r_last_i = 1; axi_r_data_i = 64'hE0 + 64'(k);
      cyc();
      axi_r_valid_i = 0; axi_r_last_i = 0;
      chk("t4_done",  64'(rw_done_o), 64'(exp_oh));
      chk("t4_rdata", rw_rdata_o, 64'hE0 + 64'(k));
    end
    rw_req_i = 2'b00;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
